// File: rtl/snn_infer_ctrl.sv
// Inference sequencer for the SNN core.
// Per inference: pulses net_reset, streams NUM_STEPS input frames (one per clock), drains the
// core pipeline with zero frames, counts out_spk per output neuron, then scans the counters to
// report the winning class (lowest index wins ties).
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   start_i               begin an inference (only honoured while idle)
//   in_frame_i            spike frame for the current timestep
//   frame_valid_i         in_frame_i valid
//   frame_ready_o         a frame is consumed this cycle (RUN)
//   net_reset_o           registered reset to the core
//   net_in_o              registered spikes to the core, zero-extended to 16 bits
//   out_spk_i             output spikes from the core
//   busy_o                high in every state except IDLE
//   done_o                one-cycle pulse when the result is valid
//   class_id_o            winning class
//   class_cnt_o           spike count of the winning class
//   tie_o                 another class shares the maximum count
//   starved_o             sticky: some RUN cycle had no valid frame
module snn_infer_ctrl #(
    parameter int unsigned NUM_IN       = 16,
    parameter int unsigned NUM_OUT      = 8,
    parameter int unsigned NUM_STEPS    = 32,
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter int unsigned CNT_W        = 6
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [NUM_IN-1:0]          in_frame_i,
    input  logic                       frame_valid_i,
    output logic                       frame_ready_o,
    output logic                       net_reset_o,
    output logic [15:0]                net_in_o,
    input  logic [NUM_OUT-1:0]         out_spk_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(NUM_OUT)-1:0] class_id_o,
    output logic [CNT_W-1:0]           class_cnt_o,
    output logic                       tie_o,
    output logic                       starved_o
);

    localparam int unsigned ClsW   = $clog2(NUM_OUT);
    localparam int unsigned MaxA   = (NUM_STEPS > RST_CYCLES) ? NUM_STEPS : RST_CYCLES;
    localparam int unsigned MaxB   = (FLUSH_CYCLES > NUM_OUT) ? FLUSH_CYCLES : NUM_OUT;
    localparam int unsigned MaxLen = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned PhW    = (MaxLen > 1) ? $clog2(MaxLen) : 1;

    localparam logic [PhW-1:0] RstLast   = PhW'(RST_CYCLES - 1);
    localparam logic [PhW-1:0] StepLast  = PhW'(NUM_STEPS - 1);
    localparam logic [PhW-1:0] FlushLast = PhW'(FLUSH_CYCLES - 1);
    localparam logic [PhW-1:0] OutLast   = PhW'(NUM_OUT - 1);

    typedef enum logic [2:0] {StIdle, StNrst, StRun, StDrain, StArgmax, StDone} state_e;

    state_e               state_q, state_d;
    logic [PhW-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]     cnt_q [NUM_OUT];
    logic [CNT_W-1:0]     cnt_d [NUM_OUT];
    logic [CNT_W-1:0]     cur_cnt;
    logic [CNT_W-1:0]     best_cnt_q, best_cnt_d;
    logic [ClsW-1:0]      best_idx_q, best_idx_d;
    logic                 best_tie_q, best_tie_d;
    logic [15:0]          net_in_d;
    logic                 last_scan;

    assign last_scan = (state_q == StArgmax) && (phase_q == OutLast);

    // Next state; the phase counter restarts at every transition.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (start_i) state_d = StNrst;
            end
            StNrst: if (phase_q == RstLast) begin
                state_d = StRun;
                phase_d = '0;
            end
            StRun: if (phase_q == StepLast) begin
                state_d = (FLUSH_CYCLES == 0) ? StArgmax : StDrain;
                phase_d = '0;
            end
            StDrain: if (phase_q == FlushLast) begin
                state_d = StArgmax;
                phase_d = '0;
            end
            StArgmax: if (phase_q == OutLast) begin
                state_d = StDone;
                phase_d = '0;
            end
            StDone: begin
                state_d = StIdle;
                phase_d = '0;
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    // Saturating per-class spike counters, live in RUN and DRAIN only.
    always_comb begin
        for (int j = 0; j < NUM_OUT; j++) begin
            cnt_d[j] = cnt_q[j];
            if (state_q == StNrst) begin
                cnt_d[j] = '0;
            end else if ((state_q == StRun || state_q == StDrain) && out_spk_i[j] &&
                         (cnt_q[j] != {CNT_W{1'b1}})) begin
                cnt_d[j] = cnt_q[j] + 1'b1;
            end
        end
    end

    // Counter selected by the argmax scan index.
    always_comb begin
        cur_cnt = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (phase_q == PhW'(j)) cur_cnt = cnt_q[j];
        end
    end

    // Sequential argmax: only a strictly greater count displaces the best, so the lowest index
    // wins ties; an equal count just flags the tie.
    always_comb begin
        best_cnt_d = best_cnt_q;
        best_idx_d = best_idx_q;
        best_tie_d = best_tie_q;
        if (state_q == StArgmax) begin
            if (phase_q == '0) begin
                best_cnt_d = cur_cnt;
                best_idx_d = '0;
                best_tie_d = 1'b0;
            end else if (cur_cnt > best_cnt_q) begin
                best_cnt_d = cur_cnt;
                best_idx_d = ClsW'(phase_q);
                best_tie_d = 1'b0;
            end else if (cur_cnt == best_cnt_q) begin
                best_tie_d = 1'b1;
            end
        end
    end

    always_comb begin
        net_in_d = '0;
        if (state_q == StRun && frame_valid_i) net_in_d[NUM_IN-1:0] = in_frame_i;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            phase_q       <= '0;
            best_cnt_q    <= '0;
            best_idx_q    <= '0;
            best_tie_q    <= 1'b0;
            frame_ready_o <= 1'b0;
            net_reset_o   <= 1'b0;
            net_in_o      <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            class_id_o    <= '0;
            class_cnt_o   <= '0;
            tie_o         <= 1'b0;
            starved_o     <= 1'b0;
            for (int j = 0; j < NUM_OUT; j++) cnt_q[j] <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            best_cnt_q    <= best_cnt_d;
            best_idx_q    <= best_idx_d;
            best_tie_q    <= best_tie_d;
            frame_ready_o <= (state_d == StRun);
            net_reset_o   <= (state_d == StNrst);
            net_in_o      <= net_in_d;
            busy_o        <= (state_d != StIdle);
            done_o        <= (state_d == StDone);
            for (int j = 0; j < NUM_OUT; j++) cnt_q[j] <= cnt_d[j];
            // Result takes the final scan step so it is visible in the DONE cycle.
            if (last_scan) begin
                class_id_o  <= best_idx_d;
                class_cnt_o <= best_cnt_d;
                tie_o       <= best_tie_d;
            end
            if (state_q == StNrst) begin
                starved_o <= 1'b0;
            end else if (state_q == StRun && !frame_valid_i) begin
                starved_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Directed bench for snn_infer_ctrl. A second instance with a 4-bit counter exercises
// saturation, which the default 6-bit counter cannot reach in one 35-cycle counting window.
module tb_snn_infer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in_frame;
    logic        frame_valid;
    logic [7:0]  out_spk;

    logic        frame_ready, net_reset, busy, done, tie, starved;
    logic [15:0] net_in;
    logic [2:0]  class_id;
    logic [5:0]  class_cnt;

    logic        s_frame_ready, s_net_reset, s_busy, s_done, s_tie, s_starved;
    logic [15:0] s_net_in;
    logic [2:0]  s_class_id;
    logic [3:0]  s_class_cnt;

    always #5 clk = ~clk;

    snn_infer_ctrl dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .in_frame_i(in_frame),
        .frame_valid_i(frame_valid), .frame_ready_o(frame_ready), .net_reset_o(net_reset),
        .net_in_o(net_in), .out_spk_i(out_spk), .busy_o(busy), .done_o(done),
        .class_id_o(class_id), .class_cnt_o(class_cnt), .tie_o(tie), .starved_o(starved)
    );

    snn_infer_ctrl #(.CNT_W(4)) dut_sat (
        .clk_i(clk), .reset_i(reset), .start_i(start), .in_frame_i(in_frame),
        .frame_valid_i(frame_valid), .frame_ready_o(s_frame_ready), .net_reset_o(s_net_reset),
        .net_in_o(s_net_in), .out_spk_i(out_spk), .busy_o(s_busy), .done_o(s_done),
        .class_id_o(s_class_id), .class_cnt_o(s_class_cnt), .tie_o(s_tie),
        .starved_o(s_starved)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] spk_pat   [0:63];
    logic       valid_pat [0:63];
    logic       busy_hist [0:60];
    int         r_done_at, r_done_cnt, r_ready_cnt, r_nrst_cnt, r_nrst_first;
    logic       r_starved3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] frame(input int t);
        logic [31:0] v;
        v = (t * 32'h1357) ^ 32'h00f0;
        return v[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pats();
        for (int i = 0; i < 64; i++) begin
            spk_pat[i]   = 8'h00;
            valid_pat[i] = 1'b1;
        end
    endtask

    // Cycle 0 carries the start pulse; cycles 1..60 are observed, then the next inputs driven.
    task automatic run_inf(input int restart_at, input int abort_at);
        logic [15:0] exp_in;
        r_done_at = -1; r_done_cnt = 0; r_ready_cnt = 0; r_nrst_cnt = 0; r_nrst_first = -1;
        r_starved3 = 1'bx;
        start = 1'b1; out_spk = spk_pat[0]; frame_valid = valid_pat[0]; in_frame = frame(0);
        for (int t = 1; t <= 60; t++) begin
            step();
            exp_in = 16'h0;
            if (t - 1 >= 3 && t - 1 <= 34 && valid_pat[t-1] && (abort_at < 0 || t - 1 < abort_at))
                exp_in = frame(t - 1);
            chk("net_in", {16'h0, net_in}, {16'h0, exp_in});
            busy_hist[t] = busy;
            if (done) begin
                r_done_cnt++;
                if (r_done_at < 0) r_done_at = t;
            end
            if (frame_ready) r_ready_cnt++;
            if (net_reset) begin
                r_nrst_cnt++;
                if (r_nrst_first < 0) r_nrst_first = t;
            end
            if (t == 3) r_starved3 = starved;
            start = (t == restart_at);
            reset = (t == abort_at);
            out_spk = spk_pat[t]; frame_valid = valid_pat[t]; in_frame = frame(t);
        end
        start = 1'b0; reset = 1'b0; out_spk = 8'h00;
    endtask

    initial begin
        // 1: reset held with start asserted
        reset = 1'b1; start = 1'b1; frame_valid = 1'b0; in_frame = 16'h0; out_spk = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_busy", {31'h0, busy}, 32'h0);
            chk("rst_done", {31'h0, done}, 32'h0);
        end
        chk("rst_net_reset", {31'h0, net_reset}, 32'h0);
        chk("rst_frame_ready", {31'h0, frame_ready}, 32'h0);
        chk("rst_net_in", {16'h0, net_in}, 32'h0);
        chk("rst_class_id", {29'h0, class_id}, 32'h0);
        chk("rst_class_cnt", {26'h0, class_cnt}, 32'h0);
        chk("rst_tie", {31'h0, tie}, 32'h0);
        chk("rst_starved", {31'h0, starved}, 32'h0);
        reset = 1'b0; start = 1'b0;
        repeat (7) step();
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // 2: latency with all-zero spikes
        clear_pats();
        run_inf(-1, -1);
        chk("lat_nrst_first", r_nrst_first, 1);
        chk("lat_nrst_cnt", r_nrst_cnt, 2);
        chk("lat_ready_cnt", r_ready_cnt, 32);
        chk("lat_done_at", r_done_at, 46);
        chk("lat_done_cnt", r_done_cnt, 1);
        chk("lat_busy_c1", {31'h0, busy_hist[1]}, 32'h1);
        chk("lat_busy_c47", {31'h0, busy_hist[47]}, 32'h0);
        chk("zero_class_id", {29'h0, class_id}, 32'h0);
        chk("zero_class_cnt", {26'h0, class_cnt}, 32'h0);
        chk("zero_tie", {31'h0, tie}, 32'h1);
        chk("lat_starved", {31'h0, starved}, 32'h0);

        // 3: argmax, with a start during the DONE cycle that must be ignored
        clear_pats();
        for (int t = 3; t <= 12; t++) spk_pat[t][5] = 1'b1;
        for (int t = 3; t <= 6; t++) spk_pat[t][2] = 1'b1;
        run_inf(46, -1);
        chk("amax_done_at", r_done_at, 46);
        chk("amax_done_cnt", r_done_cnt, 1);
        chk("amax_busy_c50", {31'h0, busy_hist[50]}, 32'h0);
        chk("amax_class_id", {29'h0, class_id}, 32'h5);
        chk("amax_class_cnt", {26'h0, class_cnt}, 32'd10);
        chk("amax_tie", {31'h0, tie}, 32'h0);
        chk("amax_s_class_cnt", {28'h0, s_class_cnt}, 32'd10);

        // 4: two classes spiking every cycle; only RUN+DRAIN (35 cycles) count
        clear_pats();
        for (int t = 0; t < 64; t++) spk_pat[t] = 8'h81;
        run_inf(-1, -1);
        chk("tie_class_id", {29'h0, class_id}, 32'h0);
        chk("tie_class_cnt", {26'h0, class_cnt}, 32'd35);
        chk("tie_tie", {31'h0, tie}, 32'h1);
        chk("sat_class_id", {29'h0, s_class_id}, 32'h0);
        chk("sat_class_cnt", {28'h0, s_class_cnt}, 32'd15);
        chk("sat_tie", {31'h0, s_tie}, 32'h1);
        chk("sat_starved", {31'h0, starved}, 32'h0);

        // 5: starvation on one RUN cycle
        clear_pats();
        valid_pat[10] = 1'b0;
        for (int t = 3; t <= 9; t++) spk_pat[t][3] = 1'b1;
        for (int t = 20; t <= 24; t++) spk_pat[t][6] = 1'b1;
        run_inf(-1, -1);
        chk("stv_done_at", r_done_at, 46);
        chk("stv_ready_cnt", r_ready_cnt, 32);
        chk("stv_starved", {31'h0, starved}, 32'h1);
        chk("stv_class_id", {29'h0, class_id}, 32'h3);
        chk("stv_class_cnt", {26'h0, class_cnt}, 32'd7);
        chk("stv_tie", {31'h0, tie}, 32'h0);

        // 6a: start mid-RUN ignored; new inference clears starved
        clear_pats();
        run_inf(5, -1);
        chk("ign_starved_c3", {31'h0, r_starved3}, 32'h0);
        chk("ign_done_at", r_done_at, 46);
        chk("ign_done_cnt", r_done_cnt, 1);
        chk("ign_tie", {31'h0, tie}, 32'h1);

        // 6b: reset at RUN step 7 aborts with no done
        clear_pats();
        run_inf(-1, 10);
        chk("abt_done_cnt", r_done_cnt, 0);
        chk("abt_ready_cnt", r_ready_cnt, 8);
        chk("abt_busy_c10", {31'h0, busy_hist[10]}, 32'h1);
        chk("abt_busy_c11", {31'h0, busy_hist[11]}, 32'h0);
        chk("abt_tie", {31'h0, tie}, 32'h0);
        chk("abt_class_id", {29'h0, class_id}, 32'h0);

        // 6c: fresh inference; DRAIN spikes count, NRST/ARGMAX spikes do not
        clear_pats();
        spk_pat[1][0] = 1'b1; spk_pat[2][0] = 1'b1;
        spk_pat[3][1] = 1'b1;
        spk_pat[36][7] = 1'b1; spk_pat[37][7] = 1'b1;
        for (int t = 38; t <= 45; t++) spk_pat[t][0] = 1'b1;
        run_inf(-1, -1);
        chk("frs_done_at", r_done_at, 46);
        chk("frs_class_id", {29'h0, class_id}, 32'h7);
        chk("frs_class_cnt", {26'h0, class_cnt}, 32'd2);
        chk("frs_tie", {31'h0, tie}, 32'h0);
        chk("frs_s_class_id", {29'h0, s_class_id}, 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
